// File: rtl/keypad_code_entry.sv
// Keypad front end for the six-digit lock controller: collects digits, strobes
// the finished code to the comparator and enforces a timed lockout after repeated failures.
module keypad_code_entry #(
  parameter int DIGITS         = 6,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           key_valid,
  input  logic [3:0]                     key_code,
  input  logic                           res_valid,
  input  logic                           res,
  output logic [3:0]                     d1,
  output logic [3:0]                     d2,
  output logic [3:0]                     d3,
  output logic [3:0]                     d4,
  output logic [3:0]                     d5,
  output logic [3:0]                     d6,
  output logic [$clog2(DIGITS+1)-1:0]    digit_count,
  output logic                           code_valid,
  output logic                           unlock,
  output logic                           locked,
  output logic [2:0]                     fail_count
);

  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [3:0] KEY_BKSP  = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DIGITS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_ENTRY, S_WAIT_RES, S_LOCKOUT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          digit_q [DIGITS];
  logic [3:0]          digit_d [DIGITS];
  logic [CNT_W-1:0]    count_q, count_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [2:0]          fail_q, fail_d;
  logic                code_valid_q, code_valid_d;
  logic                unlock_q, unlock_d;
  logic                locked_q, locked_d;

  logic [2:0] fail_inc;
  logic       key_accept;
  logic       enter_ok;

  assign fail_inc   = fail_q + 3'd1;
  // 0xD-0xF are not keys at all: they neither edit the entry nor count as activity.
  assign key_accept = key_valid && (key_code <= KEY_ENTER);
  assign enter_ok   = key_accept && (key_code == KEY_ENTER) && (count_q == CNT_FULL);

  // NOTE: every flop, including the digit array, is cleared by clr so no stale code survives reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= S_ENTRY;
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= '0;
      count_q      <= '0;
      idle_q       <= '0;
      lock_cnt_q   <= '0;
      fail_q       <= '0;
      code_valid_q <= 1'b0;
      unlock_q     <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so all flops update from the same pre-edge values.
      state_q      <= state_d;
      digit_q      <= digit_d;
      count_q      <= count_d;
      idle_q       <= idle_d;
      lock_cnt_q   <= lock_cnt_d;
      fail_q       <= fail_d;
      code_valid_q <= code_valid_d;
      unlock_q     <= unlock_d;
      locked_q     <= locked_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_ENTRY:    if (enter_ok) state_d = S_WAIT_RES;
      S_WAIT_RES: if (res_valid) begin
        if (!res && (fail_inc == 3'(MAX_FAILS))) state_d = S_LOCKOUT;
        else                                     state_d = S_ENTRY;
      end
      S_LOCKOUT:  if (lock_cnt_q == LOCK_LAST) state_d = S_ENTRY;
      default:    state_d = S_ENTRY;
    endcase
  end

  always_comb begin
    digit_d      = digit_q;
    count_d      = count_q;
    idle_d       = idle_q;
    lock_cnt_d   = lock_cnt_q;
    fail_d       = fail_q;
    code_valid_d = 1'b0;
    unlock_d     = 1'b0;
    locked_d     = (state_d == S_LOCKOUT);

    unique case (state_q)
      S_ENTRY: begin
        if (key_accept) begin
          idle_d = '0;
          if (key_code <= 4'h9) begin
            if (count_q != CNT_FULL) begin
              digit_d[count_q] = key_code;
              count_d          = count_q + CNT_W'(1);
            end
          end else if (key_code == KEY_BKSP) begin
            if (count_q != '0) begin
              digit_d[count_q - CNT_W'(1)] = 4'h0;
              count_d                      = count_q - CNT_W'(1);
            end
          end else if (key_code == KEY_CLEAR) begin
            for (int i = 0; i < DIGITS; i++) digit_d[i] = 4'h0;
            count_d = '0;
          end else begin
            code_valid_d = enter_ok;
          end
        end else if (count_q != '0) begin
          // A key in the same cycle takes the branch above, so it always beats the timeout.
          if (idle_q == IDLE_LAST) begin
            for (int i = 0; i < DIGITS; i++) digit_d[i] = 4'h0;
            count_d = '0;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end
      S_WAIT_RES: begin
        if (res_valid) begin
          for (int i = 0; i < DIGITS; i++) digit_d[i] = 4'h0;
          count_d  = '0;
          unlock_d = res;
          fail_d   = res ? 3'd0 : fail_inc;
        end
      end
      S_LOCKOUT: begin
        if (lock_cnt_q == LOCK_LAST) begin
          lock_cnt_d = '0;
          fail_d     = 3'd0;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign d1          = digit_q[0];
  assign d2          = digit_q[1];
  assign d3          = digit_q[2];
  assign d4          = digit_q[3];
  assign d5          = digit_q[4];
  assign d6          = digit_q[5];
  assign digit_count = count_q;
  assign code_valid  = code_valid_q;
  assign unlock      = unlock_q;
  assign locked      = locked_q;
  assign fail_count  = fail_q;

endmodule

// File: doc/keypad_code_entry.md
Name: keypad_code_entry

Overview:
- Front-end writer for the six-digit lock controller.
- Collects keypad digits one key strobe at a time and presents them as six parallel 4-bit digits, first-entered digit on d1.
- On ENTER, issues a one-cycle code_valid strobe, then waits for the controller's compare result.
- Counts consecutive failures and enforces a timed lockout after too many wrong attempts.

Parameters:
- DIGITS, 6: code length; fixed at 6 for this controller, and the width of digit_count follows it.
- MAX_FAILS, 3: consecutive wrong results that trigger lockout (1..7).
- LOCKOUT_CYCLES, 1000: clk cycles spent in LOCKOUT.
- TIMEOUT_CYCLES, 5000: idle cycles with a partial entry before auto-clear.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- key_valid  in  1  one-cycle strobe; key_code is sampled when high.
- key_code  in  4  0x0-0x9 digit, 0xA backspace, 0xB clear, 0xC enter, 0xD-0xF ignored.
- res_valid  in  1  one-cycle strobe from the controller; res is sampled when high.
- res  in  1  1 = code matched.
- d1..d6  out  4 each  entered digits; d1 holds the first key pressed.
- digit_count  out  3  digits currently entered (0..6).
- code_valid  out  1  one-cycle strobe; d1..d6 are stable from this cycle until res_valid.
- unlock  out  1  one-cycle pulse on a correct result.
- locked  out  1  high throughout LOCKOUT.
- fail_count  out  3  consecutive failures.

Behaviour:
- Reset (async clr=1): state=ENTRY, d1..d6=0, digit_count=0, code_valid=0, unlock=0, locked=0, fail_count=0, timers=0. All outputs are registered.
- States: ENTRY, WAIT_RES, LOCKOUT.
- ENTRY, on key_valid:
  - Digit with count<6: write it to d[count+1] and increment count. A digit with count=6 is ignored.
  - Backspace with count>0: zero d[count] and decrement count. Backspace at 0 is ignored.
  - Clear: zero all digits, count=0.
  - Enter with count=6: code_valid=1 for the next cycle, then go to WAIT_RES. Enter with count<6 is ignored and the entry is kept.
  - Codes 0xD-0xF: ignored, and the idle timer does not reset.
- Idle timer: runs in ENTRY while count>0 and resets on every accepted key. When it reaches TIMEOUT_CYCLES, clear the digits and set count=0. It never runs when count=0.
- WAIT_RES:
  - All key_valid strobes are ignored and the digits are held.
  - res_valid with res=1: unlock pulses for 1 cycle, fail_count=0, digits and count cleared, go to ENTRY.
  - res_valid with res=0: fail_count+1. If the new value equals MAX_FAILS, go to LOCKOUT. Otherwise clear the digits and go to ENTRY.
  - res_valid is only sampled in WAIT_RES; strobes in other states are dropped.
- LOCKOUT:
  - locked=1, digits cleared, keys ignored.
  - The counter counts LOCKOUT_CYCLES cycles; on expiry locked=0, fail_count=0, go to ENTRY.
- Simultaneous events:
  - key_valid and res_valid in the same cycle in WAIT_RES: res_valid is handled, the key is dropped.
  - Timeout and key_valid in the same cycle: the key wins, the timer resets, and the key is applied.
- Latency:
  - Key to updated d/count: 1 cycle.
  - Enter to code_valid: 1 cycle.
  - res_valid to unlock/locked: 1 cycle.
- Reset mid-operation: any state returns to the reset values immediately. No pending code_valid or unlock survives reset.

Test Plan:
- Keys 1,2,3,4,5,6, enter -> d1..d6=1,2,3,4,5,6, count=6, and one code_valid pulse 1 cycle after enter. Then res_valid,res=1 -> unlock pulse, count=0, fail_count=0.
- Keys 7,8,9, backspace, 0, clear -> after backspace count=2 and d3=0; after 0, d3=0 and count=3; after clear all digits are 0 and count=0. Enter at count=4 -> no code_valid.
- Seven digits 1..7 -> the 7th is ignored and d6=6. Key 0xE -> no change. Keys during WAIT_RES -> digits unchanged.
- Three wrong results (res=0) with MAX_FAILS=3, LOCKOUT_CYCLES=8 -> fail_count 1,2 then locked=1 for exactly 8 cycles. Keys are ignored during lockout. Afterwards locked=0 and fail_count=0.
- TIMEOUT_CYCLES=16: enter 2 digits, idle 16 cycles -> count=0. Press a key at cycle 15 -> the timer restarts.
- Assert clr mid-WAIT_RES and mid-LOCKOUT -> all outputs 0 asynchronously, state ENTRY. A res_valid arriving after reset -> no unlock.
